truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Self-checking stimulus/capture stage for the lab's 3-input combinational gate networks. It drives A/B/C into a downstream combinational block and samples its Y output. It also collects the 8-entry truth table and compares it against an expected vector. It is the synthesizable successor to the hand-written `$display` testbenches, so a board or simulation run gives a single pass/fail plus the per-row mismatch map.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each input vector is held before Y is sampled. Legal range is ≥1.

Ports:
- `clk`  in  1: clock. Everything is sampled on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high. The single clock is `clk`.
- `start`  in  1: request a sweep. Accepted only in IDLE.
- `expected`  in  8: expected truth table. Bit i is the expected Y for input vector i. Latched when `start` is accepted.
- `y`  in  1: output of the combinational block under test.
- `a`, `b`, `c`  out  1 each: stimulus lines. `a` is the MSB of the row index and `c` is the LSB.
- `busy`  out  1: high while a sweep is running.
- `done`  out  1: one-cycle pulse at sweep completion.
- `pass`  out  1: 1 when the captured table equals the expected table. Valid from `done` until the next accepted `start`.
- `captured`  out  8: captured table. Bit i is the Y sampled for row i.
- `mismatch`  out  8: `captured ^ expected_q`, updated together with `pass`.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE:**
  - If `start` is high, latch `expected` into `expected_q`.
  - Clear `captured`, row index `idx` (3 bits) and settle counter `cnt`.
  - Set `busy` and go to RUN.
  - If `start` is low, hold all outputs.
- **RUN:**
  - `{a,b,c}` is registered and equals `idx`.
  - `cnt` counts from 0 to SETTLE-1.
  - On the edge where `cnt == SETTLE-1`: write `y` into `captured[idx]` and clear `cnt`.
  - If `idx == 7`, go to DONE. Otherwise `idx` increments.
  - `idx` does not wrap within a sweep. Exactly 8 rows are sampled, in order 0 to 7.
- **DONE (one cycle):**
  - `done` is 1 and `busy` is 0.
  - `mismatch` and `pass` are registered on the transition into DONE, so they are valid in the same cycle as `done`.
  - Next state is IDLE.
- **Held outputs after DONE:** `captured`, `mismatch`, `pass` and `{a,b,c}` (which stays at 7) hold until the next accepted `start` or reset.
- **`start` while busy or in DONE:** ignored. No queuing and no restart.
- **`expected` changes mid-sweep:** no effect, because only `expected_q` is used.
- **Reset mid-sweep:** aborts the sweep. No `done` pulse is produced and the partial capture is discarded.
- **Reset values:** `a`=`b`=`c`=0, `busy`=0, `done`=0, `pass`=0, `captured`=0, `mismatch`=0, state=IDLE.

## Timing
- Call the edge that accepts `start` E0.
- `{a,b,c}` = 0 is visible from E0.
- Row i is sampled at edge E0 + (i+1)·SETTLE, and row i+1 is driven from that same edge.
- `done`, `pass` and `mismatch` are high/valid in the cycle after edge E0 + 8·SETTLE. With SETTLE=2, that is the cycle after E0+16.
- `busy` is high from E0 through edge E0 + 8·SETTLE, exclusive of the DONE cycle.
- The earliest re-accept of `start` is the edge two cycles after `done` rises, i.e. the first IDLE edge.
- `y` must be stable within SETTLE cycles of a stimulus change. The block is intended only for combinational (zero-latency) blocks under test.

## Configuration
- `TTC_ERR_COUNT_EN`:
  - **Defined:** adds the output port `err_count` (out, 4 bits). It carries the population count of `mismatch` (range 0–8), registered together with `pass`. Its reset value is 0 and it holds until the next accepted `start`.
  - **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan
- Use the model `y = 1` with `expected = 8'hFF` and `start` pulsed:
  - `{a,b,c}` steps 0 to 7, two cycles each.
  - `done` is high at cycle E0+17.
  - `pass` = 1, `captured` = FF, `mismatch` = 00, `err_count` = 0.
- Use the model `y = a & b` with `expected = 8'hC0`:
  - `pass` = 1, `captured` = C0.
- Repeat with `expected = 8'hC1`:
  - `pass` = 0, `mismatch` = 01, `err_count` = 1.
- Use the model `y = ~c` with `expected = 8'h00`:
  - `captured` = 55, `mismatch` = 55, `err_count` = 4.
- Pulse `start` again during RUN, and change `expected` mid-sweep:
  - The sweep timing is unchanged and only one `done` pulse occurs.
  - The result uses the originally latched `expected`.
- Assert `rst` at E0+7 with SETTLE=2:
  - On the next edge, all outputs take their reset values and no `done` pulse occurs.
  - A new `start` then gives a full, correct sweep.

Source files
------------

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - 3-input truth-table sweep, capture and compare stage
// Optional feature macro: TTC_ERR_COUNT_EN adds the err_count port (popcount of mismatch).
module truth_table_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
`ifdef TTC_ERR_COUNT_EN
    output logic [7:0] mismatch,
    output logic [3:0] err_count
`else
    output logic [7:0] mismatch
`endif
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    expected_q;
    logic [7:0]    cap_next;
    logic          row_last;

`ifdef TTC_ERR_COUNT_EN
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction
`endif

    // The row index doubles as the stimulus, so {a,b,c} holds at 7 after a sweep.
    assign {a, b, c} = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        row_last      = (cnt == CW'(SETTLE - 1));
        cap_next      = captured;
        cap_next[idx] = y;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (row_last && (idx == 3'd7)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 3'd0;
            cnt        <= '0;
            expected_q <= 8'd0;
            captured   <= 8'd0;
            mismatch   <= 8'd0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef TTC_ERR_COUNT_EN
            err_count  <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        expected_q <= expected;
                        captured   <= 8'd0;
                        idx        <= 3'd0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (row_last) begin
                        captured <= cap_next;
                        cnt      <= '0;
                        if (idx == 3'd7) begin
                            // Compare against the table including the row captured on this edge.
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mismatch <= cap_next ^ expected_q;
                            pass     <= (cap_next == expected_q);
`ifdef TTC_ERR_COUNT_EN
                            err_count <= popcount8(cap_next ^ expected_q);
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker with a plant model and random sweeps
module tb_truth_table_checker;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expected = 8'd0;
    logic       y;
    logic       a, b, c, busy, done, pass;
    logic [7:0] captured, mismatch;
`ifdef TTC_ERR_COUNT_EN
    logic [3:0] err_count;
`endif

    truth_table_checker #(.SETTLE(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .expected (expected),
        .y        (y),
        .a        (a),
        .b        (b),
        .c        (c),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .captured (captured),
`ifdef TTC_ERR_COUNT_EN
        .mismatch (mismatch),
        .err_count(err_count)
`else
        .mismatch (mismatch)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cap;
        logic [7:0] mis;
        logic       pass;
        int         errs;
    } result_t;

    result_t    sb[$];
    int         errors = 0;
    int         checks = 0;
    int         dones  = 0;
    int         pushes = 0;
    int         mode   = 0;
    logic [7:0] fn     = 8'd0;

    // Combinational block under test: 0 y=1, 1 y=a&b, 2 y=~c, 3 arbitrary table fn.
    function automatic logic plant(input int m, input logic [7:0] f, input int row);
        logic pa, pb, pc;
        pa = row[2];
        pb = row[1];
        pc = row[0];
        case (m)
            0:       return 1'b1;
            1:       return pa & pb;
            2:       return ~pc;
            default: return f[row];
        endcase
    endfunction

    assign y = plant(mode, fn, int'({a, b, c}));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic result_t reference(input int m, input logic [7:0] f, input logic [7:0] e);
        result_t r;
        r.cap = 8'd0;
        for (int i = 0; i < 8; i++) r.cap[i] = plant(m, f, i);
        r.mis  = r.cap ^ e;
        r.pass = (r.cap == e);
        r.errs = 0;
        for (int i = 0; i < 8; i++) r.errs += int'(r.mis[i]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            result_t r;
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse with empty scoreboard at %0t", $time);
            end else begin
                r = sb.pop_front();
                chk("captured", 32'(captured), 32'(r.cap));
                chk("mismatch", 32'(mismatch), 32'(r.mis));
                chk("pass", 32'(pass), 32'(r.pass));
`ifdef TTC_ERR_COUNT_EN
                chk("err_count", 32'(err_count), 32'(r.errs));
`endif
            end
        end
    end

    // One sweep; abort_at >= 1 asserts rst so that edge E0+abort_at resets the DUT.
    task automatic sweep(input int m, input logic [7:0] f, input logic [7:0] e,
                         input bit disturb, input int abort_at);
        @(negedge clk);
        mode     = m;
        fn       = f;
        expected = e;
        start    = 1'b1;
        @(posedge clk);
        if (abort_at < 0) begin
            sb.push_back(reference(m, f, e));
            pushes++;
        end
        for (int j = 0; j <= 8 * S + 2; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
            if (abort_at >= 0 && j == abort_at) begin
                chk("rst_abc", 32'({a, b, c}), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_pass", 32'(pass), 32'd0);
                chk("rst_captured", 32'(captured), 32'd0);
                chk("rst_mismatch", 32'(mismatch), 32'd0);
`ifdef TTC_ERR_COUNT_EN
                chk("rst_err_count", 32'(err_count), 32'd0);
`endif
                rst = 1'b0;
                break;
            end
            if (abort_at >= 0 && j == abort_at - 1) rst = 1'b1;
            if (j < 8 * S) begin
                chk("abc_step", 32'({a, b, c}), 32'(j / S));
                chk("busy_run", 32'(busy), 32'd1);
            end else if (j == 8 * S) begin
                chk("done_time", 32'(done), 32'd1);
                chk("busy_done", 32'(busy), 32'd0);
            end else begin
                chk("done_pulse", 32'(done), 32'd0);
                chk("abc_hold", 32'({a, b, c}), 32'd7);
                chk("busy_idle", 32'(busy), 32'd0);
            end
            if (disturb) begin
                if (j == 5) begin
                    start    = 1'b1;
                    expected = ~e;
                end
                if (j == 6) start = 1'b0;
                if (j == 8 * S) start = 1'b1;
                if (j == 8 * S + 1) start = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_abc", 32'({a, b, c}), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_captured", 32'(captured), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        sweep(0, 8'h00, 8'hFF, 1'b0, -1);
        sweep(1, 8'h00, 8'hC0, 1'b0, -1);
        sweep(1, 8'h00, 8'hC1, 1'b0, -1);
        sweep(2, 8'h00, 8'h00, 1'b0, -1);
        sweep(2, 8'h00, 8'h55, 1'b1, -1);
        sweep(1, 8'h00, 8'h3C, 1'b0, 7);
        sweep(1, 8'h00, 8'hC0, 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            int         m;
            logic [7:0] f, e;
            m = int'($urandom_range(3, 0));
            f = 8'($urandom);
            e = ($urandom_range(1, 0) == 1) ? reference(m, f, 8'd0).cap : 8'($urandom);
            sweep(m, f, e, 1'($urandom_range(1, 0)), -1);
        end

        repeat (4) @(negedge clk);
        chk("done_count", 32'(dones), 32'(pushes));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
